// File: rtl/mac_sequencer.sv
// Single-multiplier dot-product sequencer for one neuron: streams activation/weight
// pairs from two synchronous buffers, accumulates with saturation, adds bias, optional ReLU.
module mac_sequencer #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic [7:0]        bias,
  input  logic              relu_en,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        act_data,
  input  logic [7:0]        wgt_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data
);

  localparam int unsigned SUM_W = ACC_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_BIAS  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic signed [ACC_W-1:0] Q_MAX   = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] Q_MIN   = ~Q_MAX;
  localparam logic signed [SUM_W-1:0] ACC_MAX = SUM_W'({1'b0, {(ACC_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] ACC_MIN = ~ACC_MAX;

  logic [2:0]              r_state;
  logic [ADDR_W-1:0]       r_len;
  logic [7:0]              r_bias;
  logic                    r_relu;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_busy;
  logic                    r_rd_en;
  logic [ADDR_W-1:0]       r_rd_addr;
  logic                    r_data_vld;
  logic                    r_out_valid;
  logic [7:0]              r_out_data;

  logic [2:0]              w_state_nxt;
  logic [ADDR_W-1:0]       w_len_nxt;
  logic [7:0]              w_bias_nxt;
  logic                    w_relu_nxt;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic                    w_busy_nxt;
  logic                    w_rd_en_nxt;
  logic [ADDR_W-1:0]       w_rd_addr_nxt;
  logic                    w_out_valid_nxt;
  logic [7:0]              w_out_data_nxt;

  logic signed [7:0]       w_prod;
  logic signed [ACC_W-1:0] w_acc_prod;
  logic signed [ACC_W-1:0] w_acc_bias;

  // Q4.4 x Q4.4 product, floor-shifted back to Q4.4 and clamped to 8 bits
  function automatic logic signed [7:0] sat_mul(input logic signed [7:0] a,
                                                input logic signed [7:0] b);
    logic signed [15:0] prod;
    logic signed [15:0] shr;
    prod = 16'(a) * 16'(b);
    shr  = prod >>> 4;
    if (shr > 16'sd127)        sat_mul = 8'sh7F;
    else if (shr < -16'sd128)  sat_mul = 8'sh80;
    else                       sat_mul = shr[7:0];
  endfunction

  // Saturating add of a sign-extended 8-bit term into the accumulator
  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] acc,
                                                      input logic signed [7:0]       x);
    logic signed [SUM_W-1:0] sum;
    sum = SUM_W'(acc) + SUM_W'(x);
    if (sum > ACC_MAX)      sat_add = ACC_MAX[ACC_W-1:0];
    else if (sum < ACC_MIN) sat_add = ACC_MIN[ACC_W-1:0];
    else                    sat_add = sum[ACC_W-1:0];
  endfunction

  function automatic logic [7:0] finalize(input logic signed [ACC_W-1:0] acc,
                                          input logic                    relu);
    if (relu && acc < 0)  finalize = 8'h00;
    else if (acc > Q_MAX) finalize = 8'h7F;
    else if (acc < Q_MIN) finalize = 8'h80;
    else                  finalize = acc[7:0];
  endfunction

  assign w_prod     = sat_mul(act_data, wgt_data);
  assign w_acc_prod = sat_add(r_acc, w_prod);
  assign w_acc_bias = sat_add(r_acc, r_bias);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_bias_nxt      = r_bias;
    w_relu_nxt      = r_relu;
    w_acc_nxt       = r_acc;
    w_busy_nxt      = r_busy;
    w_rd_en_nxt     = r_rd_en;
    w_rd_addr_nxt   = r_rd_addr;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_len_nxt  = len;
          w_bias_nxt = bias;
          w_relu_nxt = relu_en;
          w_acc_nxt  = '0;
          w_busy_nxt = 1'b1;
          if (len != '0) begin
            w_state_nxt   = S_RUN;
            w_rd_en_nxt   = 1'b1;
            w_rd_addr_nxt = '0;
          end else begin
            w_state_nxt = S_BIAS;
          end
        end
      end
      S_RUN: begin
        if (r_data_vld) w_acc_nxt = w_acc_prod;
        if (r_rd_addr == r_len - ADDR_W'(1)) begin
          w_rd_en_nxt = 1'b0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        w_acc_nxt   = w_acc_prod;
        w_state_nxt = S_BIAS;
      end
      S_BIAS: begin
        w_acc_nxt       = w_acc_bias;
        w_out_data_nxt  = finalize(w_acc_bias, r_relu);
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_busy_nxt      = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_busy_nxt      = 1'b0;
        w_rd_en_nxt     = 1'b0;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_bias      <= '0;
      r_relu      <= 1'b0;
      r_acc       <= '0;
      r_busy      <= 1'b0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_data_vld  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_bias      <= w_bias_nxt;
      r_relu      <= w_relu_nxt;
      r_acc       <= w_acc_nxt;
      r_busy      <= w_busy_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_data_vld  <= r_rd_en;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
    end
  end

  assign busy      = r_busy;
  assign rd_en     = r_rd_en;
  assign rd_addr   = r_rd_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule
